// File: rtl/select_scan_pkg.sv
// Shared types and constants for the select-line scan sequencer.
package select_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_CODES = 8;
  localparam int unsigned CODE_W    = 3;
  localparam int unsigned DWELL_W   = 16;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/select_scan_sequencer_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled, pulses tc on the last count.
module dwell_timer
  import select_scan_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/select_scan_sequencer.sv
// Steps decoder selects {a,b,c} through all eight codes, each held DWELL cycles.
// Define SCAN_GRAY_EN to emit the Gray-coded step index instead of binary.
module select_scan_sequencer
  import select_scan_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic mode,
  output logic a,
  output logic b,
  output logic c,
  output logic step_valid,
  output logic busy,
  output logic done
);

  state_e state_q, state_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic mode_q, mode_d;
  logic sv_q, sv_d;
  logic busy_q, done_q;
  logic run_en, tc;

  // Counter is held at zero outside RUN so each scan starts a full dwell.
  assign run_en = (state_q == RUN);

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk(clk),
    .rst(rst),
    .clr(!run_en),
    .en (run_en),
    .tc (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    sv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          idx_d   = '0;
          mode_d  = mode;
          sv_d    = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tc) begin
          if ((idx_q == CODE_W'(NUM_CODES - 1)) && !mode_q) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            sv_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef SCAN_GRAY_EN
  assign code_d = bin2gray(idx_d);
`else
  assign code_d = idx_d;
`endif

  // Status flags are registered from the next state so outputs stay flop-driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      code_q  <= '0;
      mode_q  <= 1'b0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      mode_q  <= mode_d;
      sv_q    <= sv_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign a          = code_q[2];
  assign b          = code_q[1];
  assign c          = code_q[0];
  assign step_valid = sv_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_select_scan_sequencer.sv
// Bench for select_scan_sequencer: DWELL=1 and DWELL=4 instances against an elapsed-time model.
module tb_select_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b1, start1 = 1'b0, stop1 = 1'b0, mode1 = 1'b0;
  logic rst4 = 1'b1, start4 = 1'b0, stop4 = 1'b0, mode4 = 1'b0;
  logic a1, b1, c1, sv1, busy1, done1;
  logic a4, b4, c4, sv4, busy4, done4;
  logic [5:0] out1, out4;

  select_scan_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .stop(stop1), .mode(mode1),
    .a(a1), .b(b1), .c(c1), .step_valid(sv1), .busy(busy1), .done(done1)
  );

  select_scan_sequencer #(.DWELL(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .stop(stop4), .mode(mode4),
    .a(a4), .b(b4), .c(c4), .step_valid(sv4), .busy(busy4), .done(done4)
  );

  assign out1 = {a1, b1, c1, sv1, busy1, done1};
  assign out4 = {a4, b4, c4, sv4, busy4, done4};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] enc(input int i);
    logic [2:0] v;
    v = i[2:0];
`ifdef SCAN_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  // Model: t = cycles elapsed since the accepted start; code follows t/DWELL.
  typedef struct {
    bit         run;
    bit         dn;
    bit         sv;
    bit         mode;
    int         t;
    logic [2:0] code;
  } mdl_t;

  mdl_t m1, m4;

  function automatic mdl_t mstep(input mdl_t s, input int dwell,
                                 input bit r, input bit st, input bit sp, input bit md);
    mdl_t n;
    n    = s;
    n.sv = 1'b0;
    n.dn = 1'b0;
    if (r) begin
      n.run = 1'b0; n.t = 0; n.mode = 1'b0; n.code = 3'b000;
    end else if (s.run) begin
      if (sp) begin
        n.run = 1'b0;
      end else begin
        n.t = s.t + 1;
        if (!s.mode && n.t == 8 * dwell) begin
          n.run = 1'b0;
          n.dn  = 1'b1;
        end else begin
          n.code = enc((n.t / dwell) % 8);
          n.sv   = (n.t % dwell) == 0;
        end
      end
    end else if (!s.dn && st && !sp) begin
      n.run = 1'b1; n.t = 0; n.mode = md; n.code = enc(0); n.sv = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [5:0] mexp(input mdl_t s);
    return {s.code, s.sv, s.run, s.dn};
  endfunction

  task automatic tick();
    logic [2:0] p1, p4;
    p1 = out1[5:3];
    p4 = out4[5:3];
    @(posedge clk);
    m1 = mstep(m1, 1, rst1, start1, stop1, mode1);
    m4 = mstep(m4, 4, rst4, start4, stop4, mode4);
    #1;
    check("model_dut1", out1, mexp(m1));
    check("model_dut4", out4, mexp(m4));
`ifdef SCAN_GRAY_EN
    if (out1[5:3] !== p1) check("gray_hamming1", $countones(out1[5:3] ^ p1), 1);
    if (out4[5:3] !== p4) check("gray_hamming4", $countones(out4[5:3] ^ p4), 1);
`else
    if (p1 === 3'bxxx || p4 === 3'bxxx) $display("note: select outputs unknown before reset");
`endif
  endtask

  typedef struct {
    bit r, st, sp, md;
    int idx;
    bit sv, bu, dn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit st, input bit sp, input bit md,
                     input int idx, input bit sv, input bit bu, input bit dn);
    vec_t v;
    v = '{r, st, sp, md, idx, sv, bu, dn};
    tbl.push_back(v);
  endtask

  initial begin
    int done_cyc;
    int svcnt;

    m1 = '{run: 0, dn: 0, sv: 0, mode: 0, t: 0, code: 3'b000};
    m4 = m1;

    // DWELL=1 vectors: single pass, DONE handling, start+stop, continuous wrap, stop.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i < 8; i++) add(0, 0, 0, 0, i, 1, 1, 0);
    add(0, 0, 0, 0, 7, 0, 0, 1);
    add(0, 1, 0, 1, 7, 0, 0, 0);
    add(0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, 1, 0);
    for (int i = 1; i <= 9; i++) add(0, (i % 2) == 1, 0, 0, i % 8, 1, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst1 = tbl[i].r; start1 = tbl[i].st; stop1 = tbl[i].sp; mode1 = tbl[i].md;
      tick();
      check($sformatf("tbl[%0d]", i), out1,
            {enc(tbl[i].idx), tbl[i].sv, tbl[i].bu, tbl[i].dn});
    end

    // DWELL=4 directed sequences; DWELL=1 instance parked in reset.
    rst1 = 1'b1; start1 = 1'b0; stop1 = 1'b0;
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    check("reset4", out4, 6'b000000);

    start4 = 1'b1; mode4 = 1'b0;
    tick();
    start4 = 1'b0;
    done_cyc = 0;
    svcnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) tick();
      if (sv4) svcnt++;
      if (done4 && done_cyc == 0) done_cyc = cyc;
      if (cyc <= 32) check("pass4_code", out4[5:3], enc((cyc - 1) / 4));
      if (cyc == 33) check("done4_code", out4[5:3], enc(7));
    end
    check("done_cycle", done_cyc, 33);
    check("sv_pulses", svcnt, 8);

    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int cyc = 2; cyc <= 10; cyc++) tick();
    stop4 = 1'b1;
    tick();
    check("stop_hold", {out4[5:3], busy4, done4}, {enc(2), 2'b00});
    start4 = 1'b1;
    tick();
    check("start_stop_idle", {out4[5:3], busy4, done4}, {enc(2), 2'b00});
    start4 = 1'b0; stop4 = 1'b0;
    tick();

    start4 = 1'b1; mode4 = 1'b1;
    tick();
    mode4 = 1'b0;
    for (int cyc = 2; cyc <= 8; cyc++) tick();
    check("no_restart", out4[5:3], enc(1));
    start4 = 1'b0;
    for (int cyc = 9; cyc <= 22; cyc++) tick();
    check("mid_code5", {out4[5:3], busy4}, {enc(5), 1'b1});
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    check("rst_mid", out4, 6'b000000);

    // Randomized control traffic on both instances.
    rst1 = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      rst1   = ($urandom_range(199) == 0);
      start1 = ($urandom_range(7) == 0);
      stop1  = ($urandom_range(39) == 0);
      mode1  = $urandom_range(1);
      rst4   = ($urandom_range(299) == 0);
      start4 = ($urandom_range(7) == 0);
      stop4  = ($urandom_range(99) == 0);
      mode4  = $urandom_range(1);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
